// File: rtl/split_target_queue.sv
// Split-capable bus target with an in-order queue of deferred reads.
// Writes complete immediately; reads are split, aged and returned FIFO.
module split_target_queue #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int MEM_DEPTH    = 256,
    parameter int READ_LATENCY = 4,
    parameter int MAX_PENDING  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] target_addr_in,
    input  logic                  target_addr_in_valid,
    input  logic                  target_rw,
    input  logic [DATA_WIDTH-1:0] target_data_in,
    input  logic                  target_data_in_valid,
    input  logic                  split_grant,
    output logic                  split_req,
    output logic [DATA_WIDTH-1:0] target_data_out,
    output logic                  target_data_out_valid,
    output logic                  target_ack,
    output logic                  target_split_ack,
    output logic                  target_ready,
    output logic [$clog2(MAX_PENDING+1)-1:0] pending_count
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CNT_W = $clog2(MAX_PENDING + 1);
    localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;

    localparam logic [0:0] IDLE            = 1'b0;
    localparam logic [0:0] WAIT_WRITE_DATA = 1'b1;

    logic [0:0]            state;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      req_idx;
    logic [DATA_WIDTH-1:0] mem    [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] q_data [MAX_PENDING];
    logic [7:0]            q_cnt  [MAX_PENDING];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  honour;
    logic                  accept;
    logic                  push;
    logic                  wr_now;
    logic                  wr_late;
    logic                  head_rdy;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_PENDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign req_idx  = target_addr_in[IDX_W-1:0];
    assign full     = (count == CNT_W'(MAX_PENDING));
    assign honour   = split_req && split_grant;
    // Blocking accepts on a grant edge keeps write and read acks apart
    assign target_ready = (state == IDLE) && !(!target_rw && full) && !honour;
    assign accept   = target_addr_in_valid && target_ready;
    assign push     = accept && !target_rw;
    assign wr_now   = accept && target_rw && target_data_in_valid;
    assign wr_late  = (state == WAIT_WRITE_DATA) && target_data_in_valid;
    // Head is ready once its counter reaches zero on this edge
    assign head_rdy = (count != '0) && (q_cnt[rd_ptr] <= 8'd1);
    assign pending_count = count;

    wire unused_addr = ^target_addr_in;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (wr_now)
                mem[req_idx] <= target_data_in;
            else if (wr_late)
                mem[wr_idx] <= target_data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            wr_idx           <= '0;
            target_ack       <= 1'b0;
            target_split_ack <= 1'b0;
        end else begin
            target_ack       <= wr_now || wr_late || honour;
            target_split_ack <= push;
            unique case (state)
                IDLE: begin
                    if (accept && target_rw && !target_data_in_valid) begin
                        wr_idx <= req_idx;
                        state  <= WAIT_WRITE_DATA;
                    end
                end
                WAIT_WRITE_DATA: begin
                    if (target_data_in_valid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr                <= '0;
            wr_ptr                <= '0;
            count                 <= '0;
            split_req             <= 1'b0;
            target_data_out       <= '0;
            target_data_out_valid <= 1'b0;
            for (int i = 0; i < MAX_PENDING; i++) begin
                q_data[i] <= '0;
                q_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_PENDING; i++) begin
                if (q_cnt[i] != 8'd0)
                    q_cnt[i] <= q_cnt[i] - 8'd1;
            end
            // Data is captured at accept so later writes cannot alter it
            if (push) begin
                q_data[wr_ptr] <= mem[req_idx];
                q_cnt[wr_ptr]  <= 8'(READ_LATENCY);
                wr_ptr         <= nxt(wr_ptr);
            end
            if (honour) begin
                target_data_out <= q_data[rd_ptr];
                rd_ptr          <= nxt(rd_ptr);
            end
            target_data_out_valid <= honour;
            split_req             <= !honour && head_rdy;
            unique case ({push, honour})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_split_target_queue.sv
// Self-checking bench for split_target_queue.
// Directed steps with random data against a queue/memory reference model.
module tb_split_target_queue;

    localparam int DW  = 8;
    localparam int AW  = 16;
    localparam int LAT = 4;
    localparam int MP  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] target_addr_in = '0;
    logic          target_addr_in_valid = 1'b0;
    logic          target_rw = 1'b0;
    logic [DW-1:0] target_data_in = '0;
    logic          target_data_in_valid = 1'b0;
    logic          split_grant = 1'b0;
    logic          split_req;
    logic [DW-1:0] target_data_out;
    logic          target_data_out_valid;
    logic          target_ack;
    logic          target_split_ack;
    logic          target_ready;
    logic [2:0]    pending_count;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mdl [int];
    logic [DW-1:0] expq [$];

    split_target_queue #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(256),
        .READ_LATENCY(LAT), .MAX_PENDING(MP)
    ) dut (
        .clk(clk), .rst(rst),
        .target_addr_in(target_addr_in),
        .target_addr_in_valid(target_addr_in_valid),
        .target_rw(target_rw),
        .target_data_in(target_data_in),
        .target_data_in_valid(target_data_in_valid),
        .split_grant(split_grant),
        .split_req(split_req),
        .target_data_out(target_data_out),
        .target_data_out_valid(target_data_out_valid),
        .target_ack(target_ack),
        .target_split_ack(target_split_ack),
        .target_ready(target_ready),
        .pending_count(pending_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_req();
        target_addr_in_valid = 1'b0;
        target_data_in_valid = 1'b0;
        target_rw            = 1'b0;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (split_req !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        chk("req_rise", {31'd0, split_req}, 1);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        target_addr_in       = a;
        target_rw            = 1'b1;
        target_data_in       = d;
        target_data_in_valid = 1'b1;
        target_addr_in_valid = 1'b1;
        #1 chk("wr_ready", {31'd0, target_ready}, 1);
        step();
        clear_req();
        chk("wr_ack", {31'd0, target_ack}, 1);
        mdl[int'(a[7:0])] = d;
    endtask

    // Read with an empty queue, checking the full latency and return
    task automatic do_read(input logic [AW-1:0] a);
        logic [DW-1:0] e;
        int n;
        e = mdl[int'(a[7:0])];
        target_addr_in       = a;
        target_rw            = 1'b0;
        target_addr_in_valid = 1'b1;
        #1 chk("rd_ready", {31'd0, target_ready}, 1);
        step();
        clear_req();
        chk("rd_split_ack", {31'd0, target_split_ack}, 1);
        wait_req(n);
        chk("rd_latency", n, LAT);
        split_grant = 1'b1;
        step();
        split_grant = 1'b0;
        chk("rd_data", {24'd0, target_data_out}, {24'd0, e});
        chk("rd_valid", {31'd0, target_data_out_valid}, 1);
        chk("rd_ack", {31'd0, target_ack}, 1);
        chk("rd_req_drop", {31'd0, split_req}, 0);
        step();
        chk("rd_valid_pulse", {31'd0, target_data_out_valid}, 0);
        chk("rd_ack_pulse", {31'd0, target_ack}, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_req"}, {31'd0, split_req}, 0);
        chk({tag, "_dout"}, {24'd0, target_data_out}, 0);
        chk({tag, "_valid"}, {31'd0, target_data_out_valid}, 0);
        chk({tag, "_ack"}, {31'd0, target_ack}, 0);
        chk({tag, "_sack"}, {31'd0, target_split_ack}, 0);
        chk({tag, "_pend"}, {29'd0, pending_count}, 0);
    endtask

    initial begin
        logic [DW-1:0] a0;
        logic [DW-1:0] b0;
        int n;

        #1 rst = 1'b1;
        #2 check_idle_outputs("reset");
        step();
        step();
        rst = 1'b0;
        chk("reset_ready", {31'd0, target_ready}, 1);

        // Same-cycle write then read back
        do_write(16'h0010, 8'(32'hA5));
        step();
        chk("wr_ack_pulse", {31'd0, target_ack}, 0);
        do_read(16'h0010);

        // Address first, data three cycles later
        a0 = 8'($urandom);
        target_addr_in       = 16'h0030;
        target_rw            = 1'b1;
        target_addr_in_valid = 1'b1;
        step();
        clear_req();
        for (int i = 0; i < 3; i++) begin
            chk("wait_ready_low", {31'd0, target_ready}, 0);
            chk("wait_no_ack", {31'd0, target_ack}, 0);
            if (i < 2) step();
        end
        target_data_in       = a0;
        target_data_in_valid = 1'b1;
        step();
        clear_req();
        chk("late_wr_ack", {31'd0, target_ack}, 1);
        chk("late_wr_ready", {31'd0, target_ready}, 1);
        mdl[8'h30] = a0;
        do_read(16'h0030);

        // Fill the queue, hold a fifth read, still accept a write
        for (int i = 0; i < 4; i++) do_write(AW'(i), 8'($urandom));
        for (int i = 0; i < 4; i++) begin
            target_addr_in       = AW'(i);
            target_rw            = 1'b0;
            target_addr_in_valid = 1'b1;
            step();
            chk("fill_sack", {31'd0, target_split_ack}, 1);
            expq.push_back(mdl[i]);
        end
        chk("full_count", {29'd0, pending_count}, MP);
        target_addr_in = 16'h0004;
        #1 chk("full_rd_ready", {31'd0, target_ready}, 0);
        step();
        chk("full_no_sack", {31'd0, target_split_ack}, 0);
        chk("full_count_hold", {29'd0, pending_count}, MP);
        target_rw            = 1'b1;
        target_addr_in       = 16'h0005;
        target_data_in       = 8'($urandom);
        target_data_in_valid = 1'b1;
        #1 chk("full_wr_ready", {31'd0, target_ready}, 1);
        step();
        mdl[5] = target_data_in;
        clear_req();
        chk("full_wr_ack", {31'd0, target_ack}, 1);
        for (int i = 0; i < 4; i++) begin
            wait_req(n);
            split_grant = 1'b1;
            step();
            split_grant = 1'b0;
            chk("fifo_data", {24'd0, target_data_out},
                {24'd0, expq.pop_front()});
            chk("fifo_valid", {31'd0, target_data_out_valid}, 1);
            chk("fifo_ack", {31'd0, target_ack}, 1);
        end
        chk("drain_count", {29'd0, pending_count}, 0);

        // Queued read keeps old data; stray grant and long grant wait
        a0 = 8'($urandom);
        b0 = ~a0;
        do_write(16'h0020, a0);
        target_addr_in       = 16'h0020;
        target_rw            = 1'b0;
        target_addr_in_valid = 1'b1;
        step();
        clear_req();
        expq.push_back(mdl[8'h20]);
        chk("stale_sack", {31'd0, target_split_ack}, 1);
        split_grant = 1'b1;
        step();
        split_grant = 1'b0;
        chk("stray_valid", {31'd0, target_data_out_valid}, 0);
        chk("stray_count", {29'd0, pending_count}, 1);
        do_write(16'h0020, b0);
        wait_req(n);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_req", {31'd0, split_req}, 1);
            chk("hold_valid", {31'd0, target_data_out_valid}, 0);
        end
        split_grant = 1'b1;
        step();
        split_grant = 1'b0;
        chk("stale_data", {24'd0, target_data_out},
            {24'd0, expq.pop_front()});
        chk("stale_valid", {31'd0, target_data_out_valid}, 1);

        // Reset with reads queued and a write waiting for data
        step();
        for (int i = 0; i < 3; i++) begin
            target_addr_in       = AW'(i);
            target_rw            = 1'b0;
            target_addr_in_valid = 1'b1;
            step();
        end
        chk("pre_rst_count", {29'd0, pending_count}, 3);
        target_addr_in = 16'h0001;
        target_rw      = 1'b1;
        step();
        clear_req();
        chk("pre_rst_wait", {31'd0, target_ready}, 0);
        #3 rst = 1'b1;
        #1 check_idle_outputs("async_rst");
        expq.delete();
        step();
        rst = 1'b0;
        target_data_in       = 8'($urandom);
        target_data_in_valid = 1'b1;
        step();
        clear_req();
        for (int i = 0; i < 10; i++) begin
            chk("post_rst_ack", {31'd0, target_ack}, 0);
            chk("post_rst_req", {31'd0, split_req}, 0);
            chk("post_rst_sack", {31'd0, target_split_ack}, 0);
            step();
        end
        do_read(16'h0001);

        // Random write/read mix against the memory model
        for (int k = 0; k < 24; k++) begin
            logic [AW-1:0] ra;
            ra = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0 || !mdl.exists(int'(ra[7:0])))
                do_write(ra, 8'($urandom));
            else
                do_read(ra);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/split_target_queue.md
# split_target_queue

Parametrised split-capable bus target with a queue of outstanding reads. It sits on the serial bus target side like the single-transaction split target, and adds configurable data/address width and up to MAX_PENDING deferred reads in flight. Each read is answered with a split acknowledge, aged for READ_LATENCY cycles, and then returned in order through the split_req/split_grant handshake. Writes complete immediately and can be accepted while reads are pending.

## Interface
- DATA_WIDTH, 8: data bus width.
- ADDR_WIDTH, 16: bus address width.
- MEM_DEPTH, 256: words of internal memory; index = low clog2(MEM_DEPTH) address bits (min 1 bit).
- READ_LATENCY, 4: cycles a read is deferred; legal range 1..255.
- MAX_PENDING, 4: read queue depth; legal range 1..16.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- target_addr_in  in  ADDR_WIDTH  request address.
- target_addr_in_valid  in  1  request present.
- target_rw  in  1  1 = write, 0 = read.
- target_data_in  in  DATA_WIDTH  write data.
- target_data_in_valid  in  1  write data present.
- split_grant  in  1  bus grants the split return.
- split_req  out  1  registered; head read is ready to return.
- target_data_out  out  DATA_WIDTH  read return data.
- target_data_out_valid  out  1  one-cycle return strobe.
- target_ack  out  1  one-cycle completion pulse (write done or read returned).
- target_split_ack  out  1  one-cycle pulse: read accepted and deferred.
- target_ready  out  1  combinational; request can be accepted this cycle.
- pending_count  out  clog2(MAX_PENDING+1)  reads currently queued.

## Operation
- States: IDLE, WAIT_WRITE_DATA. Read queue and return logic run independently of the state.
- Accept = target_addr_in_valid && target_ready, sampled at a rising edge.
- target_ready = (state == IDLE) && !(rw==0 && queue full) && !(split_req && split_grant). The last term keeps write/read acks from colliding.
- Write accept with data_valid: mem[index] <= data; target_ack next cycle; stay IDLE.
- Write accept without data_valid: latch address, go WAIT_WRITE_DATA (target_ready low); on data_valid write mem, target_ack next cycle, go IDLE.
- Read accept: push entry {data = mem[index] at accept cycle, counter = READ_LATENCY}; target_split_ack next cycle. A write accepted later never changes a queued read's data.
- Each entry's counter decrements every cycle while nonzero. Head is eligible when its counter is 0. Returns are strictly FIFO.
- split_req <= head eligible && no return in progress. Grant is honoured only while split_req is high. Grant with split_req low is ignored.
- On honoured grant: next cycle target_data_out = head data, target_data_out_valid = 1, target_ack = 1, split_req = 0, entry popped.
- Push and pop in the same cycle are legal; pending_count is unchanged.
- Reset values: split_req 0, target_data_out 0, target_data_out_valid 0, target_ack 0, target_split_ack 0, pending_count 0, state IDLE.
- Reset mid-operation clears the queue and any pending write (dropped, no ack). Memory contents are not reset.

## Timing
- Read accepted at cycle t: target_split_ack at t+1; earliest split_req at t+1+READ_LATENCY.
- Grant at cycle g: data, valid and ack at g+1; split_req low at g+1; next head split_req at earliest g+2.
- Write with data in accept cycle t: memory updated at edge t; target_ack at t+1. A read of that address accepted at t+1 returns the new data.
- Back-to-back reads may be accepted every cycle until full. Full: target_ready low for reads and high for writes (IDLE).
- split_req stays high until granted; there is no timeout.

## Test plan
- Write 0xA5 to 0x0010 with data in the same cycle, then read 0x0010 (READ_LATENCY=4, grant held high): ack at t+1; split_ack at t'+1; split_req at t'+5; data 0xA5 with valid+ack at t'+6.
- Write address at t, data at t+3: target_ready low t+1..t+3; ack at t+4; a readback returns the written value.
- Four reads back-to-back to 0x00..0x03 holding 0x10..0x13 (MAX_PENDING=4): pending_count reaches 4; a fifth read is held (ready low) while a write is still accepted; returns 0x10..0x13 in order, each one cycle after its grant.
- Read 0x20 (holding 0x11) queued, then write 0x22 to 0x20 before the return: read still returns 0x11.
- Grant held low for 10 cycles after split_req rises: split_req stays high and no data appears; grant pulse → data next cycle; a stray grant while split_req is low has no effect.
- Assert rst with 3 reads queued and WAIT_WRITE_DATA pending: all outputs go to reset values asynchronously; pending_count 0; no acks after release; memory keeps prior values.
